// File: rtl/ctrl_74hc595_chain_pkg.sv
// Shared definitions for the 74HC595 chain driver: FSM state encoding and
// the output-enable level helper reused by other display drivers.
package ctrl_74hc595_chain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT_LO = 2'd1,
        ST_SHIFT_HI = 2'd2,
        ST_LATCH    = 2'd3
    } state_t;

    // Pin level for a logical enable, given the pin polarity.
    function automatic logic oe_level(input logic active, input logic active_low);
        return active ^ active_low;
    endfunction

endpackage

// File: rtl/ctrl_74hc595_chain_tick.sv
// Reloadable half-period down-counter: tick is high in the last cycle of
// every CLK_DIV-cycle period counted from the most recent load.
module ctrl_74hc595_chain_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] cnt_reg;

    // Reloading on every tick keeps the count in 1..CLK_DIV, so it never wraps.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt_reg <= CW'(CLK_DIV);
        end else begin
            cnt_reg <= cnt_reg - CW'(1);
        end
    end

    assign tick = (cnt_reg == CW'(1));

endmodule

// File: rtl/ctrl_74hc595_chain.sv
// Serial driver for a daisy-chain of 74HC595s: shifts a DATA_W-bit frame out
// on DS/SHCP at a divided rate, then pulses STCP; all pins come from flops.
module ctrl_74hc595_chain
    import ctrl_74hc595_chain_pkg::*;
#(
    parameter int DATA_W        = 12,
    parameter int CLK_DIV       = 2,
    parameter bit MSB_FIRST     = 1'b1,
    parameter bit OE_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_stcp,
    output logic              o_shcp,
    output logic              o_ds,
    output logic              o_oe
);
    localparam int BW = $clog2(DATA_W + 1);

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic [DATA_W-1:0] data_ordered;
    logic [BW-1:0]     bit_cnt_reg, bit_cnt_next;
    logic              ds_next;
    logic              done_next;
    logic              accept;
    logic              tick;

    // Reorder the frame so the first bit on the wire is always at index 0.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_order
        if (MSB_FIRST) begin : g_msb
            assign data_ordered[gi] = i_data[DATA_W-1-gi];
        end else begin : g_lsb
            assign data_ordered[gi] = i_data[gi];
        end
    end

    assign accept = i_valid & o_ready;

    ctrl_74hc595_chain_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .load (tick | accept),
        .tick (tick)
    );

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        ds_next      = o_ds;
        done_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next   = ST_SHIFT_LO;
                    shift_next   = data_ordered;
                    bit_cnt_next = BW'(DATA_W);
                    ds_next      = data_ordered[0];
                end
            end
            ST_SHIFT_LO: begin
                if (tick) begin
                    state_next = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (tick) begin
                    bit_cnt_next = bit_cnt_reg - BW'(1);
                    shift_next   = shift_reg >> 1;
                    if (bit_cnt_reg == BW'(1)) begin
                        state_next = ST_LATCH;
                    end else begin
                        state_next = ST_SHIFT_LO;
                        ds_next    = shift_next[0];
                    end
                end
            end
            ST_LATCH: begin
                if (tick) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Pins are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            o_ready     <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_stcp      <= 1'b0;
            o_shcp      <= 1'b0;
            o_ds        <= 1'b0;
            o_oe        <= oe_level(1'b0, OE_ACTIVE_LOW);
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            o_ready     <= (state_next == ST_IDLE);
            o_busy      <= (state_next != ST_IDLE);
            o_done      <= done_next;
            o_stcp      <= (state_next == ST_LATCH);
            o_shcp      <= (state_next == ST_SHIFT_HI);
            o_ds        <= ds_next;
            // Outputs stay dark until the first complete frame is latched.
            if (done_next) begin
                o_oe <= oe_level(1'b1, OE_ACTIVE_LOW);
            end
        end
    end

endmodule

// File: tb/tb_ctrl_74hc595_chain.sv
// Bench for ctrl_74hc595_chain: two configurations driven against a
// behavioural 74HC595 chain model with a cycle-count scoreboard.
module tb_ctrl_74hc595_chain;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [11:0] data_a;
    logic        valid_a, ready_a, busy_a, done_a, stcp_a, shcp_a, ds_a, oe_a;
    logic [7:0]  data_b;
    logic        valid_b, ready_b, busy_b, done_b, stcp_b, shcp_b, ds_b, oe_b;

    ctrl_74hc595_chain #(
        .DATA_W(12), .CLK_DIV(2), .MSB_FIRST(1'b1), .OE_ACTIVE_LOW(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .i_data(data_a), .i_valid(valid_a),
        .o_ready(ready_a), .o_busy(busy_a), .o_done(done_a), .o_stcp(stcp_a),
        .o_shcp(shcp_a), .o_ds(ds_a), .o_oe(oe_a)
    );

    ctrl_74hc595_chain #(
        .DATA_W(8), .CLK_DIV(1), .MSB_FIRST(1'b0), .OE_ACTIVE_LOW(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .i_data(data_b), .i_valid(valid_b),
        .o_ready(ready_b), .o_busy(busy_b), .o_done(done_b), .o_stcp(stcp_b),
        .o_shcp(shcp_b), .o_ds(ds_b), .o_oe(oe_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Per-configuration parameters: index 0 = dut_a, 1 = dut_b.
    int width[2]  = '{12, 8};
    int lat[2]    = '{51, 18};
    bit msb[2]    = '{1'b1, 1'b0};
    bit oe_low[2] = '{1'b1, 1'b0};

    // Model state.
    int          cyc = 0;
    logic [15:0] exp_data[2], chain[2], latch[2];
    int          bit_idx[2], acc_cyc[2], done_due[2], acc_count[2];
    int          stcp_count[2], last_done_cyc[2];
    bit          pending[2], ever_done[2], rst_prev[2];
    logic        prev_shcp[2], prev_stcp[2], first_ds[2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mask_of(input int id);
        return 16'((32'd1 << width[id]) - 32'd1);
    endfunction

    // What the parallel outputs of the chain show once a frame is latched.
    function automatic logic [15:0] exp_latch(input int id, input logic [15:0] d);
        logic [15:0] r;
        r = '0;
        if (msb[id]) return d & mask_of(id);
        for (int i = 0; i < width[id]; i++) r[width[id]-1-i] = d[i];
        return r;
    endfunction

    task automatic step(input int id, input logic shcp, input logic stcp, input logic ds,
                        input logic done, input logic busy, input logic ready,
                        input logic oe, input logic valid, input logic [15:0] data);
        string p;
        bit    busy_exp;
        int    pos;
        p = (id == 0) ? "A_" : "B_";
        if (rst) begin
            pending[id]   = 1'b0;
            ever_done[id] = 1'b0;
            bit_idx[id]   = 0;
            rst_prev[id]  = 1'b1;
            prev_shcp[id] = shcp;
            prev_stcp[id] = stcp;
            return;
        end
        busy_exp = pending[id] && (cyc > acc_cyc[id]) && (cyc < done_due[id]);
        check({p, "busy"}, busy, busy_exp);
        check({p, "ready"}, ready, !rst_prev[id] && !busy_exp);
        check({p, "done"}, done, pending[id] && (cyc == done_due[id]));
        if (shcp && !prev_shcp[id]) begin
            if (pending[id] && bit_idx[id] < width[id]) begin
                pos = msb[id] ? (width[id] - 1 - bit_idx[id]) : bit_idx[id];
                check({p, "ds_bit"}, ds, exp_data[id][pos]);
                if (bit_idx[id] == 0) first_ds[id] = ds;
                bit_idx[id]++;
            end else begin
                check({p, "shcp_extra"}, 1, 0);
            end
            chain[id] = ((chain[id] << 1) | 16'(ds)) & mask_of(id);
        end
        if (stcp && !prev_stcp[id]) begin
            stcp_count[id]++;
            check({p, "stcp_after_bits"}, pending[id] ? bit_idx[id] : 99, width[id]);
            latch[id] = chain[id];
        end
        if (done && pending[id]) begin
            check({p, "frame_latch"}, latch[id], exp_latch(id, exp_data[id]));
            pending[id]       = 1'b0;
            ever_done[id]     = 1'b1;
            last_done_cyc[id] = cyc;
        end
        check({p, "oe"}, oe, oe_low[id] ? !ever_done[id] : ever_done[id]);
        if (valid && ready) begin
            pending[id]  = 1'b1;
            acc_cyc[id]  = cyc;
            done_due[id] = cyc + lat[id];
            exp_data[id] = data;
            bit_idx[id]  = 0;
            acc_count[id]++;
        end
        rst_prev[id]  = 1'b0;
        prev_shcp[id] = shcp;
        prev_stcp[id] = stcp;
    endtask

    always @(negedge clk) begin
        step(0, shcp_a, stcp_a, ds_a, done_a, busy_a, ready_a, oe_a, valid_a, 16'(data_a));
        step(1, shcp_b, stcp_b, ds_b, done_b, busy_b, ready_b, oe_b, valid_b, 16'(data_b));
    end

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int id, input logic [15:0] d);
        int n;
        for (n = 0; n < 200; n++) begin
            if (((id == 0) ? ready_a : ready_b) === 1'b1) break;
            tick_n(1);
        end
        if (n == 200) check("send_ready_timeout", 0, 1);
        if (id == 0) begin data_a = d[11:0]; valid_a = 1'b1; end
        else         begin data_b = d[7:0];  valid_b = 1'b1; end
        tick_n(1);
        if (id == 0) valid_a = 1'b0; else valid_b = 1'b0;
    endtask

    task automatic wait_idle(input int id);
        int n;
        for (n = 0; n < 200; n++) begin
            if (!pending[id]) break;
            tick_n(1);
        end
        if (n == 200) check("idle_timeout", 0, 1);
    endtask

    task automatic wait_acc(input int id, input int target);
        int n;
        for (n = 0; n < 200; n++) begin
            if (acc_count[id] >= target) break;
            tick_n(1);
        end
        if (n == 200) check("accept_timeout", 0, 1);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_shcp"}, shcp_a, 0);
        check({tag, "_stcp"}, stcp_a, 0);
        check({tag, "_ds"}, ds_a, 0);
        check({tag, "_done"}, done_a, 0);
        check({tag, "_busy"}, busy_a, 0);
        check({tag, "_ready"}, ready_a, 0);
        check({tag, "_oe"}, oe_a, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [15:0] d;
        logic [15:0] saved_latch;
        int          saved_stcp, n0, n;

        valid_a = 1'b0; data_a = '0; valid_b = 1'b0; data_b = '0;
        rst = 1'b1;
        tick_n(3);
        check_reset_a("rst_a");
        check("rst_b_ready", ready_b, 0);
        check("rst_b_oe", oe_b, 0);
        check("rst_b_shcp", shcp_b, 0);
        rst = 1'b0;
        tick_n(1);
        check("post_rst_ready_a", ready_a, 1);
        check("post_rst_ready_b", ready_b, 1);

        // Single frame, MSB first, 51-cycle latency checked by the scoreboard.
        send(0, 16'h0B5A);
        wait_idle(0);
        $display("frame A data=b5a latch=%0h", latch[0]);
        check("t1_latch", latch[0], 16'h0B5A);
        check("t1_stcp_pulses", stcp_count[0], 1);
        check("t1_oe_on", oe_a, 0);

        // Held valid: second frame accepted in the first frame's done cycle.
        n0 = acc_count[0];
        data_a = 12'h0F0; valid_a = 1'b1;
        wait_acc(0, n0 + 1);
        data_a = 12'hA55;
        wait_acc(0, n0 + 2);
        valid_a = 1'b0;
        check("t2_no_gap", acc_cyc[0], last_done_cyc[0]);
        wait_idle(0);
        $display("frame A back-to-back 0f0,a55 latch=%0h", latch[0]);
        check("t2_latch", latch[0], 16'h0A55);

        // Valid pulses with other data while busy must be ignored.
        for (int k = 0; k < 4; k++) begin
            d = 16'($urandom_range(0, 4095));
            n0 = acc_count[0];
            send(0, d);
            for (int j = 0; j < 3; j++) begin
                tick_n($urandom_range(2, 7));
                data_a = 12'($urandom); valid_a = 1'b1;
                tick_n(1);
                valid_a = 1'b0;
            end
            wait_idle(0);
            $display("frame A data=%0h latch=%0h", d, latch[0]);
            check("t3_latch", latch[0], exp_latch(0, d));
            check("t3_accepts", acc_count[0], n0 + 1);
        end

        // Reset after five shifted bits aborts the frame without latching.
        saved_stcp  = stcp_count[0];
        saved_latch = latch[0];
        send(0, 16'($urandom_range(0, 4095)));
        for (n = 0; n < 200; n++) begin
            if (bit_idx[0] >= 5) break;
            tick_n(1);
        end
        if (n == 200) check("t4_bit_timeout", 0, 1);
        rst = 1'b1;
        tick_n(1);
        check_reset_a("t4_abort");
        rst = 1'b0;
        tick_n(60);
        $display("frame A aborted latch=%0h", latch[0]);
        check("t4_no_stcp", stcp_count[0], saved_stcp);
        check("t4_latch_kept", latch[0], saved_latch);
        check("t4_oe_off", oe_a, 1);

        // OE stays inactive through the first frame after reset, then holds.
        send(0, 16'h0123);
        tick_n(10);
        check("t6_oe_mid_first", oe_a, 1);
        wait_idle(0);
        check("t6_oe_after_first", oe_a, 0);
        send(0, 16'h0ABC);
        tick_n(10);
        check("t6_oe_mid_second", oe_a, 0);
        wait_idle(0);
        $display("frame A data=abc latch=%0h", latch[0]);
        check("t6_latch", latch[0], 16'h0ABC);

        // LSB first, CLK_DIV=1, 8 bits: 18-cycle latency.
        send(1, 16'h0001);
        wait_idle(1);
        $display("frame B data=01 first_bit=%0d latch=%0h", first_ds[1], latch[1]);
        check("t5_first_bit", first_ds[1], 1);
        check("t5_latch", latch[1], 16'h0080);
        check("t5_oe_on", oe_b, 1);
        for (int k = 0; k < 6; k++) begin
            d = 16'($urandom_range(0, 255));
            send(1, d);
            wait_idle(1);
            $display("frame B data=%0h latch=%0h", d, latch[1]);
            check("t5_rand_latch", latch[1], exp_latch(1, d));
        end

        tick_n(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
